// File: rtl/control_unit.sv
// Instruction sequencer for the accumulator CPU: fetch, operand read,
// accumulator commit, store strobe, jumps and halt.
module control_unit #(
   parameter int DATA_SIZE   = 8,
   parameter int OPCODE_SIZE = 4,
   parameter int INSTR_SIZE  = 12,
   parameter int ADDR_SIZE   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   output logic [ADDR_SIZE-1:0]         instr_addr,
   input  logic [INSTR_SIZE-1:0]        instr_rdata,
   output logic [INSTR_SIZE-1:0]        instr_reg,
   output logic signed [DATA_SIZE-1:0]  accumulator,
   output logic [ADDR_SIZE-1:0]         mem_addr,
   output logic                         mem_we,
   output logic [DATA_SIZE-1:0]         mem_wdata,
   input  logic signed [DATA_SIZE-1:0]  alu_out,
   input  logic                         we_alu,
   output logic                         halted
);

   typedef enum logic [2:0] {
      FETCH,
      LOAD_IR,
      READ,
      EXEC,
      HALT
   } state_t;

   localparam logic [OPCODE_SIZE-1:0] OP_ALU_LO = OPCODE_SIZE'(1);
   localparam logic [OPCODE_SIZE-1:0] OP_ALU_HI = OPCODE_SIZE'(11);
   localparam logic [OPCODE_SIZE-1:0] OP_JMP   = OPCODE_SIZE'(13);
   localparam logic [OPCODE_SIZE-1:0] OP_JZ    = OPCODE_SIZE'(14);
   localparam logic [OPCODE_SIZE-1:0] OP_HALT  = OPCODE_SIZE'(15);

   state_t                       state_q, state_d;
   logic [ADDR_SIZE-1:0]         pc_q, pc_d;
   logic [INSTR_SIZE-1:0]        ir_q, ir_d;
   logic signed [DATA_SIZE-1:0]  acc_q, acc_d;

   logic [OPCODE_SIZE-1:0] opcode;
   logic [ADDR_SIZE-1:0]   target;
   logic                   is_alu;
   logic                   is_jmp;
   logic                   is_jz;

   assign opcode = ir_q[INSTR_SIZE-1:INSTR_SIZE-OPCODE_SIZE];
   assign target = ir_q[ADDR_SIZE-1:0];
   assign is_alu = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
   assign is_jmp = (opcode == OP_JMP);
   assign is_jz  = (opcode == OP_JZ);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      unique case (state_q)
         FETCH: begin
            if (run) state_d = LOAD_IR;
         end
         LOAD_IR: begin
            ir_d    = instr_rdata;
            pc_d    = pc_q + ADDR_SIZE'(1);
            state_d = READ;
         end
         READ: begin
            state_d = EXEC;
         end
         EXEC: begin
            unique case (1'b1)
               is_alu:  acc_d = alu_out;
               is_jmp:  pc_d  = target;
               is_jz:   if (acc_q == '0) pc_d = target;
               default: ;
            endcase
            // a store needs no state change: the strobe is combinational
            state_d = (opcode == OP_HALT) ? HALT : FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   assign instr_addr  = pc_q;
   assign instr_reg   = ir_q;
   assign accumulator = acc_q;
   assign mem_addr    = ir_q[ADDR_SIZE-1:0];
   assign mem_wdata   = acc_q;
   assign mem_we      = rst_n && (state_q == EXEC) && we_alu;
   assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: memories and a small ALU around the DUT,
// directed scenarios plus random programs against an instruction-level model.
module tb_control_unit;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [7:0]  instr_addr;
   logic [11:0] instr_rdata;
   logic [11:0] instr_reg;
   logic [7:0]  accumulator;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  alu_out;
   logic        we_alu;
   logic        halted;

   logic [11:0] imem [256];
   logic [7:0]  dmem [256];
   logic [7:0]  dmem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   control_unit #(
      .DATA_SIZE(8), .OPCODE_SIZE(4), .INSTR_SIZE(12), .ADDR_SIZE(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .instr_addr(instr_addr), .instr_rdata(instr_rdata),
      .instr_reg(instr_reg), .accumulator(accumulator),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .alu_out(alu_out), .we_alu(we_alu), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Opcodes 1..11: LOAD ADD SUB AND OR XOR NOT SHL SHR LDI ADDI
   function automatic logic [7:0] alu_fn(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] m,
                                         input logic [7:0] imm);
      case (op)
         4'h1: return m;
         4'h2: return a + m;
         4'h3: return a - m;
         4'h4: return a & m;
         4'h5: return a | m;
         4'h6: return a ^ m;
         4'h7: return ~a;
         4'h8: return a << 1;
         4'h9: return a >> 1;
         4'hA: return imm;
         4'hB: return a + imm;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_out = alu_fn(instr_reg[11:8], accumulator, dmem_rdata,
                           instr_reg[7:0]);
   assign we_alu  = (instr_reg[11:8] == 4'hC);

   always @(posedge clk) begin
      instr_rdata <= imem[instr_addr];
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      dmem_rdata <= dmem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         imem[i] = 12'h000;
         dmem[i] = 8'h00;
      end
   endtask

   // leaves the bench in cycle 0 (FETCH, reset just released)
   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [7:0]  m_pc;
   logic [7:0]  m_acc;
   logic        m_halt;
   logic [7:0]  m_dm [256];

   task automatic model_step();
      logic [11:0] ir;
      logic [3:0]  op;
      logic [7:0]  t;
      ir   = imem[m_pc];
      op   = ir[11:8];
      t    = ir[7:0];
      m_pc = m_pc + 8'd1;
      if (op >= 4'h1 && op <= 4'hB) m_acc = alu_fn(op, m_acc, m_dm[t], t);
      else if (op == 4'hC) m_dm[t] = m_acc;
      else if (op == 4'hD) m_pc = t;
      else if (op == 4'hE && m_acc == 8'h00) m_pc = t;
      else if (op == 4'hF) m_halt = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      run   = 1'b0;
      clear_mem();

      // LDI 5, ADDI 3, STORE 0x10, HALT
      imem[0] = 12'hA05; imem[1] = 12'hB03;
      imem[2] = 12'hC10; imem[3] = 12'hF00;
      run = 1'b1;
      do_reset();
      chk("rst_acc", accumulator, 8'h00);
      chk("rst_ir", instr_reg, 12'h000);
      chk("rst_pc", instr_addr, 8'h00);
      chk("rst_halted", halted, 1'b0);
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("t1_we_c%0d", c), mem_we, (c == 11));
         if (c == 11) begin
            chk("t1_waddr", mem_addr, 8'h10);
            chk("t1_wdata", mem_wdata, 8'h08);
         end
         if (c == 4) chk("t1_acc5", accumulator, 8'h05);
         if (c >= 8) chk($sformatf("t1_acc8_c%0d", c), accumulator, 8'h08);
         chk($sformatf("t1_halt_c%0d", c), halted, (c >= 16));
         step();
      end
      chk("t1_dmem", dmem[8'h10], 8'h08);

      // JZ taken / not taken
      clear_mem();
      imem[0] = 12'hA00; imem[1] = 12'hE20;
      do_reset();
      repeat (8) step();
      chk("jz_taken", instr_addr, 8'h20);
      clear_mem();
      imem[0] = 12'hA01; imem[1] = 12'hE20;
      do_reset();
      repeat (8) step();
      chk("jz_not_taken", instr_addr, 8'h02);

      // LOAD 5, SUB 6 wraps
      clear_mem();
      dmem[5] = 8'h7F; dmem[6] = 8'h80;
      imem[0] = 12'h105; imem[1] = 12'h306;
      do_reset();
      repeat (4) step();
      chk("load_acc", accumulator, 8'h7F);
      repeat (4) step();
      chk("sub_wrap", accumulator, 8'hFF);

      // pc wrap from 0xFF
      clear_mem();
      imem[0] = 12'hDFF;
      do_reset();
      repeat (4) step();
      chk("wrap_pcff", instr_addr, 8'hFF);
      repeat (4) step();
      chk("wrap_pc0", instr_addr, 8'h00);

      // reset during EXEC of a STORE
      clear_mem();
      dmem[8'h10] = 8'h33;
      imem[0] = 12'hA05; imem[1] = 12'hC10; imem[2] = 12'hF00;
      do_reset();
      repeat (7) step();
      chk("rs_we_before", mem_we, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rs_we_supp", mem_we, 1'b0);
      step();
      chk("rs_acc", accumulator, 8'h00);
      chk("rs_ir", instr_reg, 12'h000);
      chk("rs_pc", instr_addr, 8'h00);
      chk("rs_halted", halted, 1'b0);
      chk("rs_dmem", dmem[8'h10], 8'h33);
      rst_n = 1'b1;
      repeat (2) step();
      chk("rs_refetch", instr_reg, 12'hA05);
      repeat (2) step();
      chk("rs_reexec", accumulator, 8'h05);

      // run held low, then raised
      clear_mem();
      imem[0] = 12'hC10;
      run = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         chk("idle_ir", instr_reg, 12'h000);
         chk("idle_pc", instr_addr, 8'h00);
         chk("idle_we", mem_we, 1'b0);
         step();
      end
      run = 1'b1;
      step();
      chk("run_we1", mem_we, 1'b0);
      step();
      chk("run_we2", mem_we, 1'b0);
      step();
      chk("run_we3", mem_we, 1'b1);

      // random programs against the instruction-level model
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 256; i++) begin
            imem[i] = 12'($urandom);
            if (imem[i][11:8] == 4'hF && $urandom_range(0, 3) != 0)
               imem[i][11:8] = 4'h0;
            dmem[i] = 8'($urandom);
            m_dm[i] = dmem[i];
         end
         m_pc = 8'h00; m_acc = 8'h00; m_halt = 1'b0;
         run = 1'b1;
         do_reset();
         for (int k = 0; k < 40; k++) begin
            if (!m_halt) model_step();
            repeat (4) step();
            chk($sformatf("r%0d_acc_%0d", p, k), accumulator, m_acc);
            chk($sformatf("r%0d_pc_%0d", p, k), instr_addr, m_pc);
            chk($sformatf("r%0d_halt_%0d", p, k), halted, m_halt);
         end
         for (int i = 0; i < 256; i++)
            chk($sformatf("r%0d_dmem_%0d", p, i), dmem[i], m_dm[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the accumulator CPU. It fetches instructions from instruction memory, holds them in `instr_reg` for the ALU, and presents the operand address to data memory. It commits `alu_out` into the accumulator, performs the store when the ALU raises `we_alu`, and handles the jump and halt opcodes that the ALU passes through unchanged. It sits between the two memory ports and the `alu` block.

## Interface
Parameters:
- `DATA_SIZE`, 8: accumulator and data-memory word width.
- `OPCODE_SIZE`, 4: opcode field width, at `instr_reg[INSTR_SIZE-1:INSTR_SIZE-OPCODE_SIZE]`.
- `INSTR_SIZE`, 12: instruction width.
- `ADDR_SIZE`, 8: PC and data-address width.
- Legality: both `ADDR_SIZE` and `DATA_SIZE` must be ≤ `INSTR_SIZE-OPCODE_SIZE`.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `run`  in  1: enables leaving FETCH.
- `instr_addr`  out  ADDR_SIZE: equals `pc`.
- `instr_rdata`  in  INSTR_SIZE: instruction memory data, valid 1 cycle after the address.
- `instr_reg`  out  INSTR_SIZE: current instruction, drives the ALU.
- `accumulator`  out  DATA_SIZE, signed: drives the ALU.
- `mem_addr`  out  ADDR_SIZE: equals `instr_reg[ADDR_SIZE-1:0]`.
- `mem_we`  out  1: data memory write strobe.
- `mem_wdata`  out  DATA_SIZE: equals `accumulator`.
- `alu_out`  in  DATA_SIZE, signed: ALU result.
- `we_alu`  in  1: ALU store request.
- `halted`  out  1: high in the HALT state.

## Operation
- Opcodes:
  - 0000 NOP
  - 0001–1011: ALU ops; the accumulator is written from `alu_out`.
  - 1100 STORE
  - 1101 JMP
  - 1110 JZ
  - 1111 HALT
- Jump target is `instr_reg[ADDR_SIZE-1:0]`.
- Registered state: `state`, `pc`, `instr_reg`, `accumulator`.
- FSM states: FETCH, LOAD_IR, READ, EXEC, HALT.
- FETCH: `instr_addr = pc`. If `run` = 1, go to LOAD_IR; otherwise stay in FETCH.
- LOAD_IR: `instr_reg <= instr_rdata`; `pc <= pc + 1`, wrapping from 2^ADDR_SIZE−1 to 0. Go to READ.
- READ: `mem_addr` is presented so data memory returns `from_mem_data` during EXEC. Go to EXEC.
- EXEC, by opcode:
  - 0001–1011: `accumulator <= alu_out`.
  - STORE: `mem_we` = 1 with `mem_addr` and `mem_wdata`; the accumulator is unchanged.
  - JMP: `pc <= target`.
  - JZ: `pc <= target` if `accumulator == 0` (value before this EXEC); otherwise `pc` is unchanged.
  - HALT: go to HALT.
  - All other opcodes: go to FETCH.
- HALT: absorbing state; only `rst_n` = 0 leaves it. `halted` = 1, `mem_we` = 0.
- `mem_we = rst_n && (state == EXEC) && we_alu`. It is combinational and never asserted outside EXEC or during a reset cycle.
- Arithmetic is done entirely by the ALU. The accumulator takes `alu_out` truncated to DATA_SIZE; no flags are kept.

## Timing
- Reset values: `state` = FETCH, `pc` = 0, `instr_reg` = 0, `accumulator` = 0, `halted` = 0, `mem_we` = 0.
- Instruction cadence: exactly 4 cycles per instruction when `run` is held high.
- With `rst_n` released before edge 0 and `run` = 1, instruction k has FETCH in cycle 4k and EXEC in cycle 4k+3. Its result is visible from cycle 4k+4.
- Instruction memory: 1-cycle synchronous read; the address is sampled at the end of FETCH.
- Data memory: 1-cycle synchronous read; the address is sampled at the end of READ.
- Stores: written at the rising edge ending EXEC.
- Read-after-store: a store followed by a LOAD of the same address is coherent. The LOAD's READ occurs 3 cycles after the write edge.
- Reset mid-instruction: applies on the next edge regardless of state and discards the in-flight instruction. A STORE in EXEC during a reset cycle is suppressed.
- `run` dropped: only sampled in FETCH. An instruction already past FETCH completes.
- JMP to self is legal and loops every 4 cycles.

## Test plan
- LDI 5, ADDI 3, STORE 0x10, HALT (A05, B03, C10, F00 at 0–3) -> `accumulator` = 8 from cycle 8. `mem_we` = 1 only in cycle 11, with `mem_addr` = 0x10 and `mem_wdata` = 8. `halted` = 1 from cycle 16 and stays high.
- LDI 0, JZ 0x20 -> `pc` = 0x20 after cycle 7.
- LDI 1, JZ 0x20 -> `pc` = 2 after cycle 7.
- LOAD 0x05 with mem[5] = 0x7F, then SUB 0x06 with mem[6] = 0x80 -> `accumulator` = 0xFF (wrap).
- `pc` = 0xFF with NOP at 0xFF -> `instr_addr` = 0x00 at the next FETCH.
- `rst_n` = 0 during EXEC of STORE -> `mem_we` = 0 that cycle. All registers are at reset values next cycle, and FETCH restarts at address 0.
- `run` = 0 after reset for 10 cycles -> state remains FETCH, `instr_reg` stays 0, and no `mem_we`. Raising `run` starts the first EXEC 3 cycles later.
